// File: rtl/led_per_sec_if.sv
// Board-pin bundle for the LED/UART demo: LED bank plus the UART pair.
interface led_per_sec_if;
   logic [7:0] LEDS;
   logic       TXD;
   logic       RXD;

   modport master (output LEDS, output TXD, input RXD);
   modport slave  (input LEDS, input TXD, output RXD);
endinterface

// File: rtl/led_per_sec.sv
// One-step-per-tick LED sequencer: 3-bit step on LEDS[7:5], and each new
// step number sent as an ASCII digit on an 8N1 UART line.
module led_per_sec #(
   parameter int TICKS_PER_STEP = 10_000_000,
   parameter int BAUD_DIV       = 87
) (
   input  logic          CLK,
   input  logic          RESET,
   led_per_sec_if.master pins
);

   localparam int PW = $clog2(TICKS_PER_STEP);
   localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(TICKS_PER_STEP - 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic [PW-1:0] pre_q, pre_d;
   logic [2:0]    step_q, step_d;
   logic [1:0]    state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    data_q, data_d;
   logic          txd_q, txd_d;
   logic          tick;
   logic          baud_done;

   assign tick      = (pre_q == PRE_LAST);
   assign baud_done = (baud_q == BAUD_LAST);

   always_comb begin
      pre_d  = tick ? '0 : pre_q + 1'b1;
      step_d = tick ? step_q + 3'd1 : step_q;
   end

   // Ticks outside IDLE are ignored so an ongoing frame is never disturbed.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      data_d    = data_q;
      txd_d     = txd_q;
      case (state_q)
         ST_IDLE: begin
            txd_d = 1'b1;
            if (tick) begin
               data_d  = 8'h30 + {5'b00000, step_d};
               state_d = ST_START;
               baud_d  = '0;
               txd_d   = 1'b0;
            end
         end
         ST_START: begin
            if (baud_done) begin
               baud_d    = '0;
               bit_idx_d = 3'd0;
               state_d   = ST_DATA;
               txd_d     = data_q[0];
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (baud_done) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = 3'd0;
                  state_d   = ST_STOP;
                  txd_d     = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  txd_d     = data_q[bit_idx_q + 3'd1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            if (baud_done) begin
               baud_d  = '0;
               state_d = ST_IDLE;
               txd_d   = 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         pre_q     <= '0;
         step_q    <= 3'd0;
         state_q   <= ST_IDLE;
         baud_q    <= '0;
         bit_idx_q <= 3'd0;
         data_q    <= 8'h00;
         txd_q     <= 1'b1;
      end else begin
         pre_q     <= pre_d;
         step_q    <= step_d;
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         data_q    <= data_d;
         txd_q     <= txd_d;
      end
   end

   assign pins.LEDS = {step_q, 5'b00000};
   assign pins.TXD  = txd_q;

endmodule

// File: tb/tb_led_per_sec.sv
// Randomized bench for led_per_sec: two parameterisations checked every cycle
// against a cycle-count based model of the LED step and UART frame timing.
module tb_led_per_sec;

   localparam int T_A = 16;
   localparam int B_A = 1;
   localparam int T_B = 50;
   localparam int B_B = 3;

   logic clk;
   logic rst_n;
   int   n;
   int   tests;
   int   failed;
   int   changes;
   logic [7:0] prev_leds;

   led_per_sec_if pins_a ();
   led_per_sec_if pins_b ();

   led_per_sec #(.TICKS_PER_STEP(T_A), .BAUD_DIV(B_A)) dut_a (
      .CLK   (clk),
      .RESET (rst_n),
      .pins  (pins_a.master)
   );

   led_per_sec #(.TICKS_PER_STEP(T_B), .BAUD_DIV(B_B)) dut_b (
      .CLK   (clk),
      .RESET (rst_n),
      .pins  (pins_b.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // n = rising edges since reset release; the step count is simply n / t.
   function automatic logic [7:0] model_leds(input int cyc, input int t);
      logic [7:0] s;
      s = 8'((cyc / t) % 8);
      return s << 5;
   endfunction

   function automatic logic model_txd(input int cyc, input int t, input int b);
      int k, off, pos;
      logic [7:0] ch;
      if (cyc < t) return 1'b1;
      k   = cyc / t;
      off = cyc - k * t;
      if (off >= 10 * b) return 1'b1;
      pos = off / b;
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      ch = 8'(8'h30 + (k % 8));
      return ch[pos - 1];
   endfunction

   task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("[TB] FAIL %s at n=%0d: observed %02h expected %02h", tag, n, obs, exp);
      end
   endtask

   task automatic check_all();
      check_output("leds_a", pins_a.LEDS, model_leds(n, T_A));
      check_output("txd_a", {7'd0, pins_a.TXD}, {7'd0, model_txd(n, T_A, B_A)});
      check_output("leds_b", pins_b.LEDS, model_leds(n, T_B));
      check_output("txd_b", {7'd0, pins_b.TXD}, {7'd0, model_txd(n, T_B, B_B)});
   endtask

   task automatic apply_stimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         pins_a.RXD = 1'($urandom);
         pins_b.RXD = 1'($urandom);
         @(posedge clk);
         if (rst_n) n++;
         @(negedge clk);
         check_all();
      end
   endtask

   // Reset lands between edges; outputs must clear before any clock edge.
   task automatic async_reset(input int hold);
      #2 rst_n = 1'b0;
      n = 0;
      #1;
      check_output("async_leds_a", pins_a.LEDS, 8'h00);
      check_output("async_txd_a", {7'd0, pins_a.TXD}, 8'h01);
      check_output("async_leds_b", pins_b.LEDS, 8'h00);
      check_output("async_txd_b", {7'd0, pins_b.TXD}, 8'h01);
      apply_stimulus(hold);
      rst_n = 1'b1;
   endtask

   initial begin
      tests      = 0;
      failed     = 0;
      n          = 0;
      rst_n      = 1'b0;
      pins_a.RXD = 1'b1;
      pins_b.RXD = 1'b1;

      apply_stimulus(5);
      rst_n = 1'b1;

      changes   = 0;
      prev_leds = pins_a.LEDS;
      for (int i = 0; i < 128; i++) begin
         apply_stimulus(1);
         if (pins_a.LEDS !== prev_leds) changes++;
         prev_leds = pins_a.LEDS;
      end
      check_output("changes_per_128", 8'(changes), 8'd8);
      check_output("wrap_leds", pins_a.LEDS, 8'h00);

      apply_stimulus($urandom_range(0, 40));
      for (int i = 0; i < 32; i++) begin
         if (n >= T_A && (n % T_A) == 4) break;
         apply_stimulus(1);
      end
      check_output("in_data_bit3", 8'(n % T_A), 8'd4);
      async_reset(3);
      apply_stimulus(2 * T_B + 20);

      for (int r = 0; r < 3; r++) begin
         apply_stimulus($urandom_range(5, 200));
         async_reset($urandom_range(1, 4));
         apply_stimulus(T_B + 35);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/led_per_sec.md
# led_per_sec

Free-running one-step-per-second LED sequencer with a UART status transmitter. A prescaler divides the board clock down to a step tick. A 3-bit step counter is shown on the top three LEDs. On every step, the new step number is sent as an ASCII digit on an 8N1 UART line. It is a top-level demo block that connects directly to board pins: clock, reset button, 8 LEDs and the UART pair.

## Interface
- `TICKS_PER_STEP`, default 10_000_000: clock cycles per LED step (1 s at 10 MHz); must be ≥ 2.
- `BAUD_DIV`, default 87: clock cycles per UART bit (115200 baud at 10 MHz); must be ≥ 1.
- `10*BAUD_DIV` must be less than `TICKS_PER_STEP`.
- `CLK` input 1: single system clock; all logic rising-edge.
- `RESET` input 1: asynchronous, active-low reset. Low clears all state immediately; release is synchronous to `CLK`.
- `LEDS` output 8: LED pattern, registered.
- `RXD` input 1: UART receive pin; unused, no logic depends on it; any level is legal.
- `TXD` output 1: UART transmit, 8N1, idle high, registered.

## Operation
- **Prescaler**
  - Counter `pre` runs from 0 to `TICKS_PER_STEP-1`, then wraps to 0.
  - `tick` is asserted for one cycle when `pre == TICKS_PER_STEP-1`.
- **Step counter**
  - 3-bit `step` increments on `tick`, modulo 8 (7→0).
- **LED mapping**
  - `LEDS = {step, 5'b00000}`, updated on the same edge as `step`.
  - Sequence from reset: 00000000, 00100000, 01000000, 01100000, 10000000, 10100000, 11000000, 11100000, then 00000000 and repeat.
  - LEDS[4:0] are always 0.
- **UART transmitter**
  - States: IDLE, START, DATA, STOP.
  - IDLE: `TXD = 1`. On `tick`, latch byte `8'h30 + new_step` (ASCII '0'..'7') and go to START.
  - START: `TXD = 0` for `BAUD_DIV` cycles, then DATA.
  - DATA: send 8 bits LSB-first, each held for `BAUD_DIV` cycles, using a bit index 0..7; then STOP.
  - STOP: `TXD = 1` for `BAUD_DIV` cycles, then IDLE.
  - A `tick` arriving while not in IDLE is dropped; the frame in progress is not disturbed. This cannot occur with legal parameters.
- **Reset (asynchronous, at any time)**
  - `pre = 0`, `step = 0`, `LEDS = 8'h00`, `TXD = 1`, transmitter in IDLE, baud counter 0, bit index 0.
  - A frame in progress is abandoned. No frame is sent for the reset value itself.

## Timing
- After reset release, the first `tick` and the first LEDS change occur on the `TICKS_PER_STEP`-th rising edge. Subsequent changes follow every `TICKS_PER_STEP` cycles exactly, with no drift.
- The LEDS update and the start-bit drive (`TXD` falling) happen on the same clock edge.
- Frame length is exactly `10*BAUD_DIV` cycles from start-bit edge to return to IDLE.
- A full LED cycle takes `8*TICKS_PER_STEP` cycles; LEDS = 11100000 first appears after `7*TICKS_PER_STEP` cycles.
- Output glitch-free: LEDS and TXD come directly from flops.

## Test plan
- **Reset values:** hold `RESET` = 0 for 5 cycles → `LEDS` = 00000000 and `TXD` = 1 throughout. With `RXD` toggling, nothing changes.
- **Step sequence:** with `TICKS_PER_STEP=16`, `BAUD_DIV=1` and `RESET` = 1 → `LEDS` changes at cycles 16, 32, …, 112 through 00100000 … 11100000, then returns to 00000000 at cycle 128. Exactly 8 distinct changes per 128 cycles.
- **UART frame:** with the same parameters, at the first tick → `TXD` = 0 (start), then bits of 0x31 LSB-first (1,0,0,0,1,1,0,0), then 1 (stop), one cycle each. Back to IDLE after 10 cycles.
- **Wrap frame:** on the 8th tick → the transmitted byte is 0x30 and `LEDS` = 00000000.
- **Mid-operation reset:** assert `RESET` = 0 during the DATA state of a frame → `TXD` = 1 and `LEDS` = 0 immediately, without waiting for a clock edge. After release, the next change occurs exactly `TICKS_PER_STEP` cycles later, with byte 0x31.
- **Defaults:** with `TICKS_PER_STEP=10_000_000` and `BAUD_DIV=87` → the first LEDS change occurs at cycle 10_000_000 and the frame lasts 870 cycles.
